// File: rtl/priv_1_12_mode_ctrl.sv
// priv_1_12_mode_ctrl
// Privilege-mode controller for the 1.12 privileged unit with configurable
// M/S/U support. It tracks the current privilege level, routes traps to M or
// S through medeleg/mideleg, executes MRET/SRET with WARL legalisation of the
// target mode, and emits the mstatus xPP/MPRV side-effect strobes for the CSR
// file. It also derives the effective data-access privilege under MPRV.
//
// Optional feature macro: PRIV_1_12_DEBUG_MODE_EN
//   When defined, adds a RUN/DEBUG state machine (halt request / DRET).
//   When undefined, the block is permanently in RUN and debug_mode is 0.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   trap_valid          trap commits this cycle
//   trap_is_irq         1 = interrupt (mideleg), 0 = exception (medeleg)
//   trap_cause          cause index into the delegation registers
//   medeleg, mideleg    delegation CSRs
//   mret, sret          return instruction commits this cycle
//   mstatus_mpp/spp/mprv  current mstatus fields
//   dbg_halt_req, dret  debug halt request / DRET commit (feature macro only)
//   curr_priv           current privilege level (U=0, S=1, M=3)
//   eff_data_priv       privilege level used for loads and stores
//   trap_to_s           this cycle's trap is taken in S-mode
//   mpp_wr_en/data      MPP update strobe and value
//   spp_wr_en/data      SPP update strobe and value
//   mprv_clr            clear MPRV
//   illegal_ret         MRET/SRET illegal at current level
//   debug_mode          core is in debug mode
module priv_1_12_mode_ctrl #(
   parameter int SUPPORT_S = 1,
   parameter int SUPPORT_U = 1,
   parameter int CAUSE_W   = 5
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               trap_valid,
   input  logic               trap_is_irq,
   input  logic [CAUSE_W-1:0] trap_cause,
   input  logic [31:0]        medeleg,
   input  logic [31:0]        mideleg,
   input  logic               mret,
   input  logic               sret,
   input  logic [1:0]         mstatus_mpp,
   input  logic               mstatus_spp,
   input  logic               mstatus_mprv,
   input  logic               dbg_halt_req,
   input  logic               dret,
   output logic [1:0]         curr_priv,
   output logic [1:0]         eff_data_priv,
   output logic               trap_to_s,
   output logic               mpp_wr_en,
   output logic [1:0]         mpp_wr_data,
   output logic               spp_wr_en,
   output logic               spp_wr_data,
   output logic               mprv_clr,
   output logic               illegal_ret,
   output logic               debug_mode
);

   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_M = 2'b11;
   localparam bit         HAS_S  = (SUPPORT_S != 0);
   localparam bit         HAS_U  = (SUPPORT_U != 0);
   localparam logic [1:0] LOWEST = HAS_U ? PRIV_U : PRIV_M;

   generate
      if (HAS_S && !HAS_U) begin : g_bad_cfg
         $error("priv_1_12_mode_ctrl: SUPPORT_S=1 requires SUPPORT_U=1");
      end
   endgenerate

   // WARL legalisation of a stored privilege field (MPP or saved debug prv).
   function automatic logic [1:0] legalize(input logic [1:0] m);
      case (m)
         PRIV_M:  return PRIV_M;
         PRIV_S:  return HAS_S ? PRIV_S : LOWEST;
         PRIV_U:  return HAS_U ? PRIV_U : PRIV_M;
         default: return LOWEST;
      endcase
   endfunction

   logic [1:0] priv_q;
   logic [1:0] priv_d;
   logic [1:0] ev_priv;
   logic [1:0] mpp_l;
   logic [1:0] restore_priv;
   logic       in_debug;
   logic       halt_entry;
   logic       dret_exit;
   logic       deleg_bit;
   logic       trap_s;
   logic       run_ok;

   assign mpp_l     = legalize(mstatus_mpp);
   assign deleg_bit = trap_is_irq ? mideleg[trap_cause] : medeleg[trap_cause];
   assign trap_s    = HAS_S && (priv_q != PRIV_M) && deleg_bit;
   // Debug entry outranks every architectural event committing in that cycle.
   assign run_ok    = !RST && !in_debug && !halt_entry;

`ifdef PRIV_1_12_DEBUG_MODE_EN
   typedef enum logic {RUN = 1'b0, DEBUG = 1'b1} dbg_state_t;

   dbg_state_t state_q;
   dbg_state_t state_d;
   logic [1:0] dcsr_prv_q;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Privilege saved on halt; only read after a halt has written it.
   always_ff @(posedge CLK) begin
      if (!RST && halt_entry) dcsr_prv_q <= priv_q;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:   if (dbg_halt_req) state_d = DEBUG;
         DEBUG: if (dret)         state_d = RUN;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_debug   = (state_q == DEBUG);
      halt_entry = (state_q == RUN) && dbg_halt_req;
      dret_exit  = (state_q == DEBUG) && dret;
   end

   assign restore_priv = legalize(dcsr_prv_q);
`else
   logic unused_dbg_inputs;
   assign unused_dbg_inputs = dbg_halt_req ^ dret;
   assign in_debug     = 1'b0;
   assign halt_entry   = 1'b0;
   assign dret_exit    = 1'b0;
   assign restore_priv = PRIV_M;
`endif

   // Architectural events (trap > mret > sret) and their CSR strobes.
   always_comb begin
      ev_priv     = priv_q;
      trap_to_s   = 1'b0;
      mpp_wr_en   = 1'b0;
      mpp_wr_data = 2'b00;
      spp_wr_en   = 1'b0;
      spp_wr_data = 1'b0;
      mprv_clr    = 1'b0;
      illegal_ret = 1'b0;
      if (run_ok) begin
         if (trap_valid) begin
            if (trap_s) begin
               ev_priv     = PRIV_S;
               trap_to_s   = 1'b1;
               spp_wr_en   = 1'b1;
               spp_wr_data = priv_q[0];
            end else begin
               ev_priv     = PRIV_M;
               mpp_wr_en   = 1'b1;
               mpp_wr_data = priv_q;
            end
         end else if (mret) begin
            if (priv_q == PRIV_M) begin
               ev_priv     = mpp_l;
               mpp_wr_en   = 1'b1;
               mpp_wr_data = LOWEST;
               mprv_clr    = (mpp_l != PRIV_M);
            end else begin
               illegal_ret = 1'b1;
            end
         end else if (sret) begin
            if (!HAS_S || priv_q == PRIV_U) begin
               illegal_ret = 1'b1;
            end else begin
               ev_priv     = mstatus_spp ? PRIV_S : PRIV_U;
               spp_wr_en   = 1'b1;
               spp_wr_data = 1'b0;
               mprv_clr    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      priv_d = ev_priv;
      if (halt_entry)     priv_d = PRIV_M;
      else if (dret_exit) priv_d = restore_priv;
   end

   always_ff @(posedge CLK) begin
      if (RST) priv_q <= PRIV_M;
      else     priv_q <= priv_d;
   end

   assign curr_priv     = priv_q;
   assign debug_mode    = in_debug;
   assign eff_data_priv = (mstatus_mprv && !in_debug) ? mpp_l : priv_q;

endmodule

// File: tb/tb_priv_1_12_mode_ctrl.sv
module tb_priv_1_12_mode_ctrl;

   typedef struct packed {
      logic [1:0] priv;
      logic       dbg;
      logic       to_s;
      logic       mpp_en;
      logic [1:0] mpp_d;
      logic       spp_en;
      logic       spp_d;
      logic       mprv_clr;
      logic       ill;
   } rec_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic        trap_valid, trap_is_irq, mret, sret;
   logic [4:0]  trap_cause;
   logic [31:0] medeleg, mideleg;
   logic [1:0]  mstatus_mpp;
   logic        mstatus_spp, mstatus_mprv, dbg_halt_req, dret;

   logic [1:0] curr_priv, eff_data_priv, mpp_wr_data;
   logic       trap_to_s, mpp_wr_en, spp_wr_en, spp_wr_data, mprv_clr, illegal_ret, debug_mode;
   logic [1:0] curr_priv_ns, eff_data_priv_ns, mpp_wr_data_ns;
   logic       trap_to_s_ns, mpp_wr_en_ns, spp_wr_en_ns, spp_wr_data_ns, mprv_clr_ns;
   logic       illegal_ret_ns, debug_mode_ns;

   int checks = 0;
   int failures = 0;

   rec_t  sbq[$];
   string nmq[$];
   rec_t  obsq[$];

   always #5 CLK = ~CLK;

   priv_1_12_mode_ctrl #(.SUPPORT_S(1), .SUPPORT_U(1), .CAUSE_W(5)) dut (
      .CLK(CLK), .RST(RST), .trap_valid(trap_valid), .trap_is_irq(trap_is_irq),
      .trap_cause(trap_cause), .medeleg(medeleg), .mideleg(mideleg), .mret(mret), .sret(sret),
      .mstatus_mpp(mstatus_mpp), .mstatus_spp(mstatus_spp), .mstatus_mprv(mstatus_mprv),
      .dbg_halt_req(dbg_halt_req), .dret(dret), .curr_priv(curr_priv),
      .eff_data_priv(eff_data_priv), .trap_to_s(trap_to_s), .mpp_wr_en(mpp_wr_en),
      .mpp_wr_data(mpp_wr_data), .spp_wr_en(spp_wr_en), .spp_wr_data(spp_wr_data),
      .mprv_clr(mprv_clr), .illegal_ret(illegal_ret), .debug_mode(debug_mode));

   priv_1_12_mode_ctrl #(.SUPPORT_S(0), .SUPPORT_U(1), .CAUSE_W(5)) dut_ns (
      .CLK(CLK), .RST(RST), .trap_valid(trap_valid), .trap_is_irq(trap_is_irq),
      .trap_cause(trap_cause), .medeleg(medeleg), .mideleg(mideleg), .mret(mret), .sret(sret),
      .mstatus_mpp(mstatus_mpp), .mstatus_spp(mstatus_spp), .mstatus_mprv(mstatus_mprv),
      .dbg_halt_req(dbg_halt_req), .dret(dret), .curr_priv(curr_priv_ns),
      .eff_data_priv(eff_data_priv_ns), .trap_to_s(trap_to_s_ns), .mpp_wr_en(mpp_wr_en_ns),
      .mpp_wr_data(mpp_wr_data_ns), .spp_wr_en(spp_wr_en_ns), .spp_wr_data(spp_wr_data_ns),
      .mprv_clr(mprv_clr_ns), .illegal_ret(illegal_ret_ns), .debug_mode(debug_mode_ns));

   function automatic rec_t mk(input logic [1:0] p, input logic d, input logic ts,
                               input logic me, input logic [1:0] md, input logic se,
                               input logic sd, input logic mc, input logic il);
      rec_t r;
      r.priv = p; r.dbg = d; r.to_s = ts; r.mpp_en = me; r.mpp_d = md;
      r.spp_en = se; r.spp_d = sd; r.mprv_clr = mc; r.ill = il;
      return r;
   endfunction

   task automatic expect_rec(input string n, input rec_t r);
      sbq.push_back(r);
      nmq.push_back(n);
   endtask

   // Called at posedge+1 with inputs already set: samples the commit-cycle
   // strobes before the edge, then the registered mode after it.
   task automatic run_cycle(input bit ns);
      rec_t o;
      #2;
      o.to_s     = ns ? trap_to_s_ns   : trap_to_s;
      o.mpp_en   = ns ? mpp_wr_en_ns   : mpp_wr_en;
      o.mpp_d    = ns ? mpp_wr_data_ns : mpp_wr_data;
      o.spp_en   = ns ? spp_wr_en_ns   : spp_wr_en;
      o.spp_d    = ns ? spp_wr_data_ns : spp_wr_data;
      o.mprv_clr = ns ? mprv_clr_ns    : mprv_clr;
      o.ill      = ns ? illegal_ret_ns : illegal_ret;
      @(posedge CLK);
      #1;
      o.priv = ns ? curr_priv_ns  : curr_priv;
      o.dbg  = ns ? debug_mode_ns : debug_mode;
      obsq.push_back(o);
      trap_valid = 0; mret = 0; sret = 0; dbg_halt_req = 0; dret = 0;
   endtask

   task automatic set_trap(input logic irq, input logic [4:0] cause);
      trap_valid = 1; trap_is_irq = irq; trap_cause = cause;
   endtask

   task automatic test_reset();
      rec_t e, o; string n;
      RST = 1; trap_valid = 1; mret = 1; mstatus_mpp = 2'b00;
      expect_rec("reset_with_events", mk(2'd3,0,0,0,2'd0,0,0,0,0)); run_cycle(0);
      RST = 0;
      expect_rec("reset_idle", mk(2'd3,0,0,0,2'd0,0,0,0,0)); run_cycle(0);
      checks++;
      if (eff_data_priv !== 2'd3) begin
         failures++; $display("FAIL reset_eff_priv: got=%0d exp=3", eff_data_priv);
      end
      while (sbq.size() > 0) begin
         e = sbq.pop_front(); n = nmq.pop_front(); checks++;
         if (obsq.size() == 0) begin failures++; $display("FAIL %s: no output captured", n); end
         else begin
            o = obsq.pop_front();
            if (o !== e) begin failures++; $display("FAIL %s: got=%b exp=%b", n, o, e); end
         end
      end
   endtask

   task automatic test_mret();
      rec_t e, o; string n;
      mstatus_mpp = 2'b00; mret = 1;
      expect_rec("mret_to_u", mk(2'd0,0,0,1,2'd0,0,0,1,0)); run_cycle(0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front(); n = nmq.pop_front(); checks++;
         if (obsq.size() == 0) begin failures++; $display("FAIL %s: no output captured", n); end
         else begin
            o = obsq.pop_front();
            if (o !== e) begin failures++; $display("FAIL %s: got=%b exp=%b", n, o, e); end
         end
      end
   endtask

   task automatic test_trap_deleg();
      rec_t e, o; string n;
      medeleg = 32'h0000_0100; mideleg = 32'h0;
      set_trap(0, 5'd8);
      expect_rec("exc8_from_u", mk(2'd1,0,1,0,2'd0,1,0,0,0)); run_cycle(0);
      set_trap(1, 5'd9);
      expect_rec("irq9_from_s", mk(2'd3,0,0,1,2'd1,0,0,0,0)); run_cycle(0);
      set_trap(0, 5'd8);
      expect_rec("exc8_from_m", mk(2'd3,0,0,1,2'd3,0,0,0,0)); run_cycle(0);
      mstatus_mpp = 2'b01; mret = 1;
      expect_rec("mret_to_s", mk(2'd1,0,0,1,2'd0,0,0,1,0)); run_cycle(0);
      set_trap(0, 5'd8);
      expect_rec("exc8_from_s", mk(2'd1,0,1,0,2'd0,1,1,0,0)); run_cycle(0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front(); n = nmq.pop_front(); checks++;
         if (obsq.size() == 0) begin failures++; $display("FAIL %s: no output captured", n); end
         else begin
            o = obsq.pop_front();
            if (o !== e) begin failures++; $display("FAIL %s: got=%b exp=%b", n, o, e); end
         end
      end
   endtask

   task automatic test_sret();
      rec_t e, o; string n;
      mstatus_spp = 0; sret = 1;
      expect_rec("sret_s_to_u", mk(2'd0,0,0,0,2'd0,1,0,1,0)); run_cycle(0);
      sret = 1;
      expect_rec("sret_in_u_illegal", mk(2'd0,0,0,0,2'd0,0,0,0,1)); run_cycle(0);
      mret = 1;
      expect_rec("mret_in_u_illegal", mk(2'd0,0,0,0,2'd0,0,0,0,1)); run_cycle(0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front(); n = nmq.pop_front(); checks++;
         if (obsq.size() == 0) begin failures++; $display("FAIL %s: no output captured", n); end
         else begin
            o = obsq.pop_front();
            if (o !== e) begin failures++; $display("FAIL %s: got=%b exp=%b", n, o, e); end
         end
      end
   endtask

   task automatic test_mpp_legal();
      rec_t e, o; string n;
      logic [1:0] mpp_tab [4];
      logic [1:0] eff_tab [4];
      mpp_tab = '{2'b11, 2'b10, 2'b01, 2'b00};
      eff_tab = '{2'd3, 2'd0, 2'd1, 2'd0};
      set_trap(0, 5'd2);
      expect_rec("exc2_from_u", mk(2'd3,0,0,1,2'd0,0,0,0,0)); run_cycle(0);
      mstatus_mpp = 2'b10; mret = 1;
      expect_rec("mret_mpp10", mk(2'd0,0,0,1,2'd0,0,0,1,0)); run_cycle(0);
      mstatus_mprv = 1;
      for (int i = 0; i < 4; i++) begin
         mstatus_mpp = mpp_tab[i];
         #1;
         checks++;
         if (eff_data_priv !== eff_tab[i]) begin
            failures++;
            $display("FAIL eff_mprv_mpp%b: got=%0d exp=%0d", mpp_tab[i], eff_data_priv, eff_tab[i]);
         end
      end
      mstatus_mprv = 0; mstatus_mpp = 2'b11;
      #1;
      checks++;
      if (eff_data_priv !== 2'd0) begin
         failures++; $display("FAIL eff_no_mprv: got=%0d exp=0", eff_data_priv);
      end
      @(posedge CLK); #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front(); n = nmq.pop_front(); checks++;
         if (obsq.size() == 0) begin failures++; $display("FAIL %s: no output captured", n); end
         else begin
            o = obsq.pop_front();
            if (o !== e) begin failures++; $display("FAIL %s: got=%b exp=%b", n, o, e); end
         end
      end
   endtask

   task automatic test_priority();
      rec_t e, o; string n;
      set_trap(0, 5'd2);
      expect_rec("exc2_to_m", mk(2'd3,0,0,1,2'd0,0,0,0,0)); run_cycle(0);
      set_trap(0, 5'd2); mret = 1; mstatus_mpp = 2'b00;
      expect_rec("trap_beats_mret", mk(2'd3,0,0,1,2'd3,0,0,0,0)); run_cycle(0);
      mret = 1; sret = 1; mstatus_mpp = 2'b01; mstatus_spp = 0;
      expect_rec("mret_beats_sret", mk(2'd1,0,0,1,2'd0,0,0,1,0)); run_cycle(0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front(); n = nmq.pop_front(); checks++;
         if (obsq.size() == 0) begin failures++; $display("FAIL %s: no output captured", n); end
         else begin
            o = obsq.pop_front();
            if (o !== e) begin failures++; $display("FAIL %s: got=%b exp=%b", n, o, e); end
         end
      end
   endtask

   task automatic test_back_to_back();
      rec_t e, o; string n;
      set_trap(0, 5'd8);
      expect_rec("b2b_exc8_s", mk(2'd1,0,1,0,2'd0,1,1,0,0)); run_cycle(0);
      sret = 1; mstatus_spp = 1;
      expect_rec("b2b_sret_to_s", mk(2'd1,0,0,0,2'd0,1,0,1,0)); run_cycle(0);
      sret = 1; mstatus_spp = 0;
      expect_rec("b2b_sret_to_u", mk(2'd0,0,0,0,2'd0,1,0,1,0)); run_cycle(0);
      set_trap(1, 5'd9);
      expect_rec("b2b_irq9_to_m", mk(2'd3,0,0,1,2'd0,0,0,0,0)); run_cycle(0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front(); n = nmq.pop_front(); checks++;
         if (obsq.size() == 0) begin failures++; $display("FAIL %s: no output captured", n); end
         else begin
            o = obsq.pop_front();
            if (o !== e) begin failures++; $display("FAIL %s: got=%b exp=%b", n, o, e); end
         end
      end
   endtask

   task automatic test_reset_mid_event();
      rec_t e, o; string n;
      mstatus_mpp = 2'b00; mret = 1;
      expect_rec("rme_mret_to_u", mk(2'd0,0,0,1,2'd0,0,0,1,0)); run_cycle(0);
      RST = 1; set_trap(0, 5'd8);
      expect_rec("rme_reset_discards", mk(2'd3,0,0,0,2'd0,0,0,0,0)); run_cycle(0);
      RST = 0;
      expect_rec("rme_idle_after", mk(2'd3,0,0,0,2'd0,0,0,0,0)); run_cycle(0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front(); n = nmq.pop_front(); checks++;
         if (obsq.size() == 0) begin failures++; $display("FAIL %s: no output captured", n); end
         else begin
            o = obsq.pop_front();
            if (o !== e) begin failures++; $display("FAIL %s: got=%b exp=%b", n, o, e); end
         end
      end
   endtask

   task automatic test_no_s();
      rec_t e, o; string n;
      RST = 1;
      expect_rec("ns_reset", mk(2'd3,0,0,0,2'd0,0,0,0,0)); run_cycle(1);
      RST = 0; sret = 1; mstatus_spp = 0;
      expect_rec("ns_sret_at_m_illegal", mk(2'd3,0,0,0,2'd0,0,0,0,1)); run_cycle(1);
      mstatus_mpp = 2'b01; mret = 1;
      expect_rec("ns_mret_mpp01_to_u", mk(2'd0,0,0,1,2'd0,0,0,1,0)); run_cycle(1);
      medeleg = 32'hFFFF_FFFF; set_trap(0, 5'd8);
      expect_rec("ns_trap_ignores_deleg", mk(2'd3,0,0,1,2'd0,0,0,0,0)); run_cycle(1);
      mstatus_mprv = 1; mstatus_mpp = 2'b01;
      #1;
      checks++;
      if (eff_data_priv_ns !== 2'd0) begin
         failures++; $display("FAIL ns_eff_mpp01: got=%0d exp=0", eff_data_priv_ns);
      end
      mstatus_mprv = 0;
      @(posedge CLK); #1;
      while (sbq.size() > 0) begin
         e = sbq.pop_front(); n = nmq.pop_front(); checks++;
         if (obsq.size() == 0) begin failures++; $display("FAIL %s: no output captured", n); end
         else begin
            o = obsq.pop_front();
            if (o !== e) begin failures++; $display("FAIL %s: got=%b exp=%b", n, o, e); end
         end
      end
   endtask

   task automatic test_debug();
      rec_t e, o; string n;
      RST = 1;
      expect_rec("dbg_reset", mk(2'd3,0,0,0,2'd0,0,0,0,0)); run_cycle(0);
      RST = 0; mstatus_mpp = 2'b00; mret = 1;
      expect_rec("dbg_mret_to_u", mk(2'd0,0,0,1,2'd0,0,0,1,0)); run_cycle(0);
`ifdef PRIV_1_12_DEBUG_MODE_EN
      dbg_halt_req = 1; set_trap(0, 5'd8);
      expect_rec("dbg_halt_beats_trap", mk(2'd3,1,0,0,2'd0,0,0,0,0)); run_cycle(0);
      medeleg = 32'hFFFF_FFFF; set_trap(0, 5'd8);
      expect_rec("dbg_trap_ignored", mk(2'd3,1,0,0,2'd0,0,0,0,0)); run_cycle(0);
      mret = 1;
      expect_rec("dbg_mret_ignored", mk(2'd3,1,0,0,2'd0,0,0,0,0)); run_cycle(0);
      sret = 1;
      expect_rec("dbg_sret_ignored", mk(2'd3,1,0,0,2'd0,0,0,0,0)); run_cycle(0);
      mstatus_mprv = 1; mstatus_mpp = 2'b00;
      #1;
      checks++;
      if (eff_data_priv !== 2'd3) begin
         failures++; $display("FAIL dbg_eff_forced_m: got=%0d exp=3", eff_data_priv);
      end
      mstatus_mprv = 0;
      @(posedge CLK); #1;
      dret = 1;
      expect_rec("dbg_dret_restores_u", mk(2'd0,0,0,0,2'd0,0,0,0,0)); run_cycle(0);
`else
      dbg_halt_req = 1;
      expect_rec("nodbg_halt_ignored", mk(2'd0,0,0,0,2'd0,0,0,0,0)); run_cycle(0);
      dret = 1;
      expect_rec("nodbg_dret_ignored", mk(2'd0,0,0,0,2'd0,0,0,0,0)); run_cycle(0);
`endif
      while (sbq.size() > 0) begin
         e = sbq.pop_front(); n = nmq.pop_front(); checks++;
         if (obsq.size() == 0) begin failures++; $display("FAIL %s: no output captured", n); end
         else begin
            o = obsq.pop_front();
            if (o !== e) begin failures++; $display("FAIL %s: got=%b exp=%b", n, o, e); end
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1; trap_valid = 0; trap_is_irq = 0; trap_cause = '0; mret = 0; sret = 0;
      medeleg = '0; mideleg = '0; mstatus_mpp = 2'b00; mstatus_spp = 0; mstatus_mprv = 0;
      dbg_halt_req = 0; dret = 0;
      @(posedge CLK); #1;
      test_reset();
      test_mret();
      test_trap_deleg();
      test_sret();
      test_mpp_legal();
      test_priority();
      test_back_to_back();
      test_reset_mid_event();
      test_no_s();
      test_debug();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
